// File: rtl/pcie_us_pkg.sv
// Shared definitions for the UltraScale PCIe AXI stream blocks:
// legal widths, the CC tuser width rule and small elaboration helpers.
package pcie_us_pkg;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } cc_mux_state_t;

  localparam int PCIE_DWORD_BITS = 32;

  function automatic bit pcie_data_width_legal(input int dw);
    return (dw == 64) || (dw == 128) || (dw == 256) || (dw == 512);
  endfunction

  function automatic int pcie_cc_user_width(input int dw);
    return (dw < 512) ? 33 : 81;
  endfunction

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pcie_us_axis_skid_reg.sv
// Two-entry registered AXI stream stage: fully registered outputs and a
// registered input ready, with a temp slot to absorb the ready latency.
module pcie_us_axis_skid_reg #(
  parameter int DATA_W = 256,
  parameter int KEEP_W = 8,
  parameter int USER_W = 33
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic [KEEP_W-1:0] s_tkeep,
  input  logic              s_tvalid,
  output logic              s_tready,
  input  logic              s_tlast,
  input  logic [USER_W-1:0] s_tuser,
  output logic [DATA_W-1:0] m_tdata,
  output logic [KEEP_W-1:0] m_tkeep,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_tlast,
  output logic [USER_W-1:0] m_tuser
);

  localparam int PW = DATA_W + KEEP_W + USER_W + 1;

  logic [PW-1:0] s_payload;
  logic [PW-1:0] m_payload_reg;
  logic [PW-1:0] temp_payload_reg;
  logic          m_valid_reg;
  logic          temp_valid_reg;
  logic          s_ready_reg;
  logic          m_valid_next;
  logic          temp_valid_next;
  logic          s_ready_early;
  logic          store_in_to_out;
  logic          store_in_to_temp;
  logic          store_temp_to_out;

  assign s_payload = {s_tdata, s_tkeep, s_tuser, s_tlast};
  assign {m_tdata, m_tkeep, m_tuser, m_tlast} = m_payload_reg;
  assign m_tvalid  = m_valid_reg;
  assign s_tready  = s_ready_reg;

  // Ready for next cycle if the output drains, or the temp slot stays free.
  assign s_ready_early = m_tready || (!temp_valid_reg && (!m_valid_reg || !s_tvalid));

  always_comb begin
    m_valid_next      = m_valid_reg;
    temp_valid_next   = temp_valid_reg;
    store_in_to_out   = 1'b0;
    store_in_to_temp  = 1'b0;
    store_temp_to_out = 1'b0;
    if (s_ready_reg) begin
      if (m_tready || !m_valid_reg) begin
        m_valid_next    = s_tvalid;
        store_in_to_out = 1'b1;
      end else begin
        temp_valid_next  = s_tvalid;
        store_in_to_temp = 1'b1;
      end
    end else if (m_tready) begin
      m_valid_next      = temp_valid_reg;
      temp_valid_next   = 1'b0;
      store_temp_to_out = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_ready_reg      <= 1'b0;
      m_valid_reg      <= 1'b0;
      temp_valid_reg   <= 1'b0;
      m_payload_reg    <= '0;
      temp_payload_reg <= '0;
    end else begin
      s_ready_reg    <= s_ready_early;
      m_valid_reg    <= m_valid_next;
      temp_valid_reg <= temp_valid_next;
      if (store_in_to_out) begin
        m_payload_reg <= s_payload;
      end else if (store_temp_to_out) begin
        m_payload_reg <= temp_payload_reg;
      end
      if (store_in_to_temp) begin
        temp_payload_reg <= s_payload;
      end
    end
  end

endmodule

// File: rtl/pcie_us_axis_cc_mux.sv
// Merges S_COUNT completer completion streams into the core's CC port with
// frame-atomic round-robin arbitration and a registered skid-buffer output.
module pcie_us_axis_cc_mux
  import pcie_us_pkg::*;
#(
  parameter int S_COUNT                 = 2,
  parameter int AXIS_PCIE_DATA_WIDTH    = 256,
  parameter int AXIS_PCIE_KEEP_WIDTH    = AXIS_PCIE_DATA_WIDTH / 32,
  parameter int AXIS_PCIE_CC_USER_WIDTH = pcie_cc_user_width(AXIS_PCIE_DATA_WIDTH),
  localparam int IDX_W                  = clog2_min1(S_COUNT)
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [S_COUNT*AXIS_PCIE_DATA_WIDTH-1:0]    s_axis_cc_tdata,
  input  logic [S_COUNT*AXIS_PCIE_KEEP_WIDTH-1:0]    s_axis_cc_tkeep,
  input  logic [S_COUNT-1:0]                         s_axis_cc_tvalid,
  output logic [S_COUNT-1:0]                         s_axis_cc_tready,
  input  logic [S_COUNT-1:0]                         s_axis_cc_tlast,
  input  logic [S_COUNT*AXIS_PCIE_CC_USER_WIDTH-1:0] s_axis_cc_tuser,
  output logic [AXIS_PCIE_DATA_WIDTH-1:0]            m_axis_cc_tdata,
  output logic [AXIS_PCIE_KEEP_WIDTH-1:0]            m_axis_cc_tkeep,
  output logic                                       m_axis_cc_tvalid,
  input  logic                                       m_axis_cc_tready,
  output logic                                       m_axis_cc_tlast,
  output logic [AXIS_PCIE_CC_USER_WIDTH-1:0]         m_axis_cc_tuser,
  input  logic                                       enable,
  output logic                                       busy,
  output logic [IDX_W-1:0]                           grant_index
);

  localparam int DW = AXIS_PCIE_DATA_WIDTH;
  localparam int KW = AXIS_PCIE_KEEP_WIDTH;
  localparam int UW = AXIS_PCIE_CC_USER_WIDTH;

  if (!pcie_data_width_legal(DW) || (KW * PCIE_DWORD_BITS != DW)) begin : g_bad_width
    $error("pcie_us_axis_cc_mux: illegal AXIS_PCIE_DATA_WIDTH/AXIS_PCIE_KEEP_WIDTH");
  end
  if ((S_COUNT < 1) || (S_COUNT > 16)) begin : g_bad_count
    $error("pcie_us_axis_cc_mux: S_COUNT must be 1..16");
  end

  cc_mux_state_t   state;
  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] rr_sel;
  logic             rr_found;
  int               rr_cand;

  logic [DW-1:0] gnt_tdata;
  logic [KW-1:0] gnt_tkeep;
  logic [UW-1:0] gnt_tuser;
  logic          gnt_tlast;
  logic          gnt_tvalid;
  logic          skid_s_valid;
  logic          skid_s_ready;
  logic          beat_accept;

  // Round-robin: scan starting one past the last grantee, take the first requester.
  always_comb begin
    rr_found = 1'b0;
    rr_sel   = '0;
    rr_cand  = 0;
    for (int k = 0; k < S_COUNT; k++) begin
      rr_cand = int'(last_grant) + 1 + k;
      if (rr_cand >= S_COUNT) begin
        rr_cand = rr_cand - S_COUNT;
      end
      for (int i = 0; i < S_COUNT; i++) begin
        if (!rr_found && (i == rr_cand) && s_axis_cc_tvalid[i]) begin
          rr_found = 1'b1;
          rr_sel   = IDX_W'(i);
        end
      end
    end
  end

  always_comb begin
    gnt_tdata        = '0;
    gnt_tkeep        = '0;
    gnt_tuser        = '0;
    gnt_tlast        = 1'b0;
    gnt_tvalid       = 1'b0;
    s_axis_cc_tready = '0;
    for (int i = 0; i < S_COUNT; i++) begin
      if (grant_index == IDX_W'(i)) begin
        gnt_tdata           = s_axis_cc_tdata[i*DW +: DW];
        gnt_tkeep           = s_axis_cc_tkeep[i*KW +: KW];
        gnt_tuser           = s_axis_cc_tuser[i*UW +: UW];
        gnt_tlast           = s_axis_cc_tlast[i];
        gnt_tvalid          = s_axis_cc_tvalid[i];
        s_axis_cc_tready[i] = (state == ST_ACTIVE) && skid_s_ready;
      end
    end
  end

  assign skid_s_valid = (state == ST_ACTIVE) && gnt_tvalid;
  assign beat_accept  = skid_s_valid && skid_s_ready;

  // Ownership only changes on the tlast handshake, so frames never interleave.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      busy        <= 1'b0;
      grant_index <= '0;
      last_grant  <= IDX_W'(S_COUNT - 1);
    end else begin
      case (state)
        ST_IDLE: begin
          if (enable && rr_found) begin
            grant_index <= rr_sel;
            busy        <= 1'b1;
            state       <= ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          if (beat_accept && gnt_tlast) begin
            last_grant <= grant_index;
            busy       <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  pcie_us_axis_skid_reg #(
    .DATA_W(DW),
    .KEEP_W(KW),
    .USER_W(UW)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_tdata  (gnt_tdata),
    .s_tkeep  (gnt_tkeep),
    .s_tvalid (skid_s_valid),
    .s_tready (skid_s_ready),
    .s_tlast  (gnt_tlast),
    .s_tuser  (gnt_tuser),
    .m_tdata  (m_axis_cc_tdata),
    .m_tkeep  (m_axis_cc_tkeep),
    .m_tvalid (m_axis_cc_tvalid),
    .m_tready (m_axis_cc_tready),
    .m_tlast  (m_axis_cc_tlast),
    .m_tuser  (m_axis_cc_tuser)
  );

endmodule

// File: tb/tb_pcie_us_axis_cc_mux.sv
// Directed self-checking bench for pcie_us_axis_cc_mux with two 256-bit sources.
`timescale 1ns/1ps
module tb_pcie_us_axis_cc_mux;

  localparam int S  = 2;
  localparam int DW = 256;
  localparam int KW = 8;
  localparam int UW = 33;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic [UW-1:0] user;
    logic          last;
  } beat_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [S*DW-1:0] s_tdata = '0;
  logic [S*KW-1:0] s_tkeep = '0;
  logic [S-1:0]    s_tvalid = '0;
  logic [S-1:0]    s_tready;
  logic [S-1:0]    s_tlast = '0;
  logic [S*UW-1:0] s_tuser = '0;
  logic [DW-1:0]   m_tdata;
  logic [KW-1:0]   m_tkeep;
  logic            m_tvalid;
  logic            m_tready = 1'b1;
  logic            m_tlast;
  logic [UW-1:0]   m_tuser;
  logic            enable = 1'b1;
  logic            busy;
  logic [0:0]      grant_index;

  beat_t q0[$];
  beat_t q1[$];
  beat_t out_q[$];
  int    out_cyc[$];
  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;

  always #5 clk = ~clk;

  pcie_us_axis_cc_mux #(
    .S_COUNT(S),
    .AXIS_PCIE_DATA_WIDTH(DW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_cc_tdata(s_tdata), .s_axis_cc_tkeep(s_tkeep), .s_axis_cc_tvalid(s_tvalid),
    .s_axis_cc_tready(s_tready), .s_axis_cc_tlast(s_tlast), .s_axis_cc_tuser(s_tuser),
    .m_axis_cc_tdata(m_tdata), .m_axis_cc_tkeep(m_tkeep), .m_axis_cc_tvalid(m_tvalid),
    .m_axis_cc_tready(m_tready), .m_axis_cc_tlast(m_tlast), .m_axis_cc_tuser(m_tuser),
    .enable(enable), .busy(busy), .grant_index(grant_index)
  );

  function automatic beat_t make_beat(input int src, input int frame, input int idx, input int nbeats);
    beat_t b;
    logic [31:0] w;
    w      = {8'(src), 8'(frame), 8'(idx), 8'hA5};
    b.data = {~w, {7{w}}};
    b.last = (idx == nbeats - 1);
    b.keep = b.last ? 8'h0F : 8'hFF;
    b.user = {1'b1, w ^ 32'h0F0F_0000};
    return b;
  endfunction

  task automatic load_frame(input int src, input int frame, input int nbeats);
    for (int i = 0; i < nbeats; i++) begin
      if (src == 0) q0.push_back(make_beat(src, frame, i, nbeats));
      else          q1.push_back(make_beat(src, frame, i, nbeats));
    end
  endtask

  task automatic present();
    s_tvalid = '0; s_tdata = '0; s_tkeep = '0; s_tuser = '0; s_tlast = '0;
    if (q0.size() > 0) begin
      s_tvalid[0] = 1'b1; s_tdata[0 +: DW] = q0[0].data; s_tkeep[0 +: KW] = q0[0].keep;
      s_tuser[0 +: UW] = q0[0].user; s_tlast[0] = q0[0].last;
    end
    if (q1.size() > 0) begin
      s_tvalid[1] = 1'b1; s_tdata[DW +: DW] = q1[0].data; s_tkeep[KW +: KW] = q1[0].keep;
      s_tuser[UW +: UW] = q1[0].user; s_tlast[1] = q1[0].last;
    end
  endtask

  // Handshakes are judged at the negedge before the edge that completes them.
  task automatic step();
    logic  hs0, hs1;
    beat_t ob, tmp;
    hs0 = s_tvalid[0] && s_tready[0];
    hs1 = s_tvalid[1] && s_tready[1];
    if (m_tvalid && m_tready) begin
      ob.data = m_tdata; ob.keep = m_tkeep; ob.user = m_tuser; ob.last = m_tlast;
      out_q.push_back(ob);
      out_cyc.push_back(cyc);
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (hs0 && q0.size() > 0) tmp = q0.pop_front();
    if (hs1 && q1.size() > 0) tmp = q1.pop_front();
    present();
  endtask

  task automatic drain(input int n, input int budget, output bit ok);
    int k;
    k = 0;
    while (out_q.size() < n && k < budget) begin
      step();
      k++;
    end
    ok = (out_q.size() >= n);
  endtask

  task automatic clear_log();
    out_q.delete();
    out_cyc.delete();
  endtask

  task automatic test_reset();
    bit ok;
    $display("[TB] test_reset");
    rst_n = 1'b0; enable = 1'b1; m_tready = 1'b1;
    q0.delete(); q1.delete(); present();
    repeat (3) @(negedge clk);
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_m_tvalid: got %b, expected 0", m_tvalid); end
    checks++; if (s_tready !== 2'b00) begin errors++; $display("[TB] FAIL reset_s_tready: got %b, expected 00", s_tready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b, expected 0", busy); end
    checks++; if (grant_index !== 1'b0) begin errors++; $display("[TB] FAIL reset_grant: got %0d, expected 0", grant_index); end
    checks++; if (m_tdata !== '0) begin errors++; $display("[TB] FAIL reset_m_tdata: got %h, expected 0", m_tdata); end
    rst_n = 1'b1;
    load_frame(1, 0, 4);
    present();
    repeat (3) step();
    checks++; if (busy !== 1'b1 || grant_index !== 1'b1) begin errors++; $display("[TB] FAIL midframe_grant: got busy %b idx %0d, expected busy 1 idx 1", busy, grant_index); end
    checks++; if (m_tvalid !== 1'b1) begin errors++; $display("[TB] FAIL midframe_m_tvalid: got %b, expected 1", m_tvalid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL async_m_tvalid: got %b, expected 0", m_tvalid); end
    checks++; if (s_tready !== 2'b00) begin errors++; $display("[TB] FAIL async_s_tready: got %b, expected 00", s_tready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL async_busy: got %b, expected 0", busy); end
    q0.delete(); q1.delete(); present();
    @(negedge clk);
    rst_n = 1'b1;
    clear_log();
    load_frame(0, 0, 1);
    load_frame(1, 0, 1);
    present();
    step();
    checks++; if (busy !== 1'b1 || grant_index !== 1'b0) begin errors++; $display("[TB] FAIL first_grant: got busy %b idx %0d, expected busy 1 idx 0", busy, grant_index); end
    drain(2, 20, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL reset_drain: got %0d beats, expected 2", out_q.size()); end
    if (ok) begin
      checks++; if (out_q[0] !== make_beat(0, 0, 0, 1)) begin errors++; $display("[TB] FAIL reset_beat0: got %h, expected %h", out_q[0], make_beat(0, 0, 0, 1)); end
      checks++; if (out_q[1] !== make_beat(1, 0, 0, 1)) begin errors++; $display("[TB] FAIL reset_beat1: got %h, expected %h", out_q[1], make_beat(1, 0, 0, 1)); end
    end
    repeat (3) step();
  endtask

  task automatic test_contention();
    bit    ok;
    beat_t exp;
    int    fr, d;
    $display("[TB] test_contention");
    clear_log();
    for (int f = 0; f < 2; f++) begin
      load_frame(0, f, 3);
      load_frame(1, f, 3);
    end
    present();
    drain(12, 100, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL contention_drain: got %0d beats, expected 12", out_q.size()); end
    for (int n = 0; n < 12 && n < out_q.size(); n++) begin
      fr  = n / 3;
      exp = make_beat(fr % 2, fr / 2, n % 3, 3);
      checks++; if (out_q[n] !== exp) begin errors++; $display("[TB] FAIL contention_beat%0d: got %h, expected %h", n, out_q[n], exp); end
      if (n > 0) begin
        d = out_cyc[n] - out_cyc[n-1];
        checks++; if (d != ((n % 3 == 0) ? 2 : 1)) begin errors++; $display("[TB] FAIL contention_gap%0d: got %0d cycles, expected %0d", n, d, (n % 3 == 0) ? 2 : 1); end
      end
    end
    repeat (3) step();
  endtask

  task automatic test_backpressure();
    bit [0:9] rdy     = 10'b1100111111;
    bit [0:9] exp_rdy = 10'b0110011000;
    bit [0:9] exp_mv  = 10'b0011111100;
    beat_t    exp;
    $display("[TB] test_backpressure");
    clear_log();
    load_frame(0, 0, 4);
    present();
    for (int k = 0; k < 10; k++) begin
      m_tready = rdy[k];
      checks++; if (s_tready !== {1'b0, exp_rdy[k]}) begin errors++; $display("[TB] FAIL bp_s_tready_c%0d: got %b, expected %b", k, s_tready, {1'b0, exp_rdy[k]}); end
      checks++; if (m_tvalid !== exp_mv[k]) begin errors++; $display("[TB] FAIL bp_m_tvalid_c%0d: got %b, expected %b", k, m_tvalid, exp_mv[k]); end
      if (k >= 2 && k <= 4) begin
        exp = make_beat(0, 0, 0, 4);
        checks++; if (m_tdata !== exp.data) begin errors++; $display("[TB] FAIL bp_hold_c%0d: got %h, expected %h", k, m_tdata, exp.data); end
      end
      step();
    end
    m_tready = 1'b1;
    checks++; if (out_q.size() != 4) begin errors++; $display("[TB] FAIL bp_count: got %0d beats, expected 4", out_q.size()); end
    for (int n = 0; n < 4 && n < out_q.size(); n++) begin
      exp = make_beat(0, 0, n, 4);
      checks++; if (out_q[n] !== exp) begin errors++; $display("[TB] FAIL bp_beat%0d: got %h, expected %h", n, out_q[n], exp); end
    end
  endtask

  task automatic test_enable();
    bit [0:11] exp_busy = 12'b011111000001;
    bit        ok;
    beat_t     exp;
    $display("[TB] test_enable");
    clear_log();
    load_frame(0, 1, 5);
    present();
    for (int k = 0; k < 12; k++) begin
      if (k == 1) begin load_frame(1, 1, 1); present(); end
      if (k == 3) enable = 1'b0;
      if (k == 10) enable = 1'b1;
      checks++; if (busy !== exp_busy[k]) begin errors++; $display("[TB] FAIL en_busy_c%0d: got %b, expected %b", k, busy, exp_busy[k]); end
      if (k >= 6 && k <= 10) begin
        checks++; if (s_tready !== 2'b00) begin errors++; $display("[TB] FAIL en_blocked_c%0d: got %b, expected 00", k, s_tready); end
      end
      if (k == 11) begin
        checks++; if (grant_index !== 1'b1) begin errors++; $display("[TB] FAIL en_grant: got %0d, expected 1", grant_index); end
        checks++; if (s_tready !== 2'b10) begin errors++; $display("[TB] FAIL en_s_tready: got %b, expected 10", s_tready); end
      end
      step();
    end
    drain(6, 30, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL en_drain: got %0d beats, expected 6", out_q.size()); end
    for (int n = 0; n < 6 && n < out_q.size(); n++) begin
      exp = (n < 5) ? make_beat(0, 1, n, 5) : make_beat(1, 1, 0, 1);
      checks++; if (out_q[n] !== exp) begin errors++; $display("[TB] FAIL en_beat%0d: got %h, expected %h", n, out_q[n], exp); end
    end
    repeat (3) step();
  endtask

  task automatic test_back_to_back();
    bit    ok;
    beat_t exp;
    int    d;
    $display("[TB] test_back_to_back");
    clear_log();
    for (int f = 0; f < 4; f++) load_frame(1, 2 + f, 1);
    present();
    drain(4, 40, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL b2b_drain: got %0d beats, expected 4", out_q.size()); end
    checks++; if (grant_index !== 1'b1) begin errors++; $display("[TB] FAIL b2b_grant: got %0d, expected 1", grant_index); end
    for (int n = 0; n < 4 && n < out_q.size(); n++) begin
      exp = make_beat(1, 2 + n, 0, 1);
      checks++; if (out_q[n] !== exp) begin errors++; $display("[TB] FAIL b2b_beat%0d: got %h, expected %h", n, out_q[n], exp); end
      if (n > 0) begin
        d = out_cyc[n] - out_cyc[n-1];
        checks++; if (d != 2) begin errors++; $display("[TB] FAIL b2b_gap%0d: got %0d cycles, expected 2", n, d); end
      end
    end
    repeat (2) step();
  endtask

  initial begin
    test_reset();
    test_contention();
    test_backpressure();
    test_enable();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/pcie_us_axis_cc_mux.md
# pcie_us_axis_cc_mux

Ultrascale PCIe CC (completer completion) multiplexer: merges completion streams from S_COUNT completer endpoints into the single CC AXI stream driven into the PCIe hard core. Arbitration is round-robin and frame-atomic: once granted, an input owns the output until its tlast beat is accepted. It sits on the return path of the CQ demultiplexer, between per-function/BAR completers and the core's s_axis_cc port. Output is fully registered through a two-entry skid buffer.

## Interface
- S_COUNT, 2: number of completion sources (1..16).
- AXIS_PCIE_DATA_WIDTH, 256: PCIe AXI stream width; 64, 128, 256 or 512 only.
- AXIS_PCIE_KEEP_WIDTH, AXIS_PCIE_DATA_WIDTH/32: dword-granular keep width.
- AXIS_PCIE_CC_USER_WIDTH, (AXIS_PCIE_DATA_WIDTH < 512 ? 33 : 81): CC tuser width.

- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- s_axis_cc_tdata  in  S_COUNT*AXIS_PCIE_DATA_WIDTH  per-source data, source i at slice i.
- s_axis_cc_tkeep  in  S_COUNT*AXIS_PCIE_KEEP_WIDTH  per-source keep.
- s_axis_cc_tvalid  in  S_COUNT  per-source valid.
- s_axis_cc_tready  out  S_COUNT  per-source ready; at most one bit high.
- s_axis_cc_tlast  in  S_COUNT  per-source last.
- s_axis_cc_tuser  in  S_COUNT*AXIS_PCIE_CC_USER_WIDTH  per-source user.
- m_axis_cc_tdata/tkeep/tvalid/tready/tlast/tuser  out/out/out/in/out/out  AXIS_PCIE_DATA_WIDTH/KEEP_WIDTH/1/1/1/CC_USER_WIDTH  merged stream to core.
- enable  in  1  0 blocks new grants; an in-progress frame completes.
- busy  out  1  high while a frame is granted (state ACTIVE).
- grant_index  out  $clog2(S_COUNT) (min 1)  index of current/last grantee.

## Operation
- Elaboration-time check: illegal data width or KEEP_WIDTH*32 != DATA_WIDTH -> $error, $finish.
- FSM states: IDLE, ACTIVE.
- IDLE: if enable and any s_axis_cc_tvalid, pick requester by round-robin starting at (last_grant+1) mod S_COUNT; register grant_index, go ACTIVE. No s_tready in IDLE.
- After reset last_grant = S_COUNT-1, so source 0 has top priority first.
- ACTIVE: s_axis_cc_tready[grant_index] = skid-buffer input ready; all other tready bits 0. Accepted beat (valid&&ready on granted source) is written into skid buffer with tdata/tkeep/tlast/tuser unmodified.
- Accepted beat with tlast -> IDLE next cycle; last_grant <= grant_index.
- Frames never interleave; tvalid on non-granted sources is held off indefinitely (no timeout).
- Skid buffer: output reg + temp reg. Input ready registered = !temp_valid next cycle (early-ready computed as output-ready-and-valid or temp empty with output/input not both valid). Data order strictly preserved; no beat dropped or duplicated.
- enable deasserted in ACTIVE: ignored until tlast accepted; then stays IDLE.

## Timing
- Reset (rst_n low, async): state IDLE, m_axis_cc_tvalid 0, s_axis_cc_tready 0, busy 0, grant_index 0, skid regs valid 0, data regs 0.
- Grant latency: request seen in IDLE cycle N -> tready for grantee high in cycle N+1.
- Data latency: beat accepted cycle N -> m_axis_cc_tvalid in cycle N+1.
- Inter-frame bubble: exactly one IDLE cycle between tlast acceptance and next grant; back-to-back single-beat frames sustain 1 beat / 2 cycles per output, full rate within a frame.
- m_axis_cc_tready low: at most 2 beats buffered; s_tready drops the cycle after temp fills; m_axis_cc_tvalid and payload stay stable until accepted.
- Simultaneous tlast acceptance and new request: grant decided in following IDLE cycle using updated last_grant.

## Structure
- Shared package pcie_us_pkg: width legality constants, CC_USER width function, clog2-min-1 helper.
- One sub-module: pcie_us_axis_skid_reg (two-entry registered AXI stream stage, same async active-low reset), instantiated once on the output.
- Round-robin arbiter coded inline (priority rotate + find-first).

## Test plan
- Reset: rst_n low mid-frame from source 1 -> m_tvalid 0, s_tready 2'b00, busy 0 immediately; after release source 0 is granted first.
- Contention: S_COUNT=2, both sources present 3-beat frames continuously -> output order src0, src1, src0, src1; no interleaved beats; 1 idle cycle between frames.
- Backpressure: m_axis_cc_tready toggled 1-0-0-1 during 4-beat frame -> all 4 beats emerge in order, tdata/tkeep/tuser bit-exact, s_tready falls after 2 buffered beats.
- Enable: enable=0 asserted on beat 2 of a 5-beat frame -> frame completes, then no grant while source 1 valid; enable=1 -> grant to source 1 next cycle.
- Width sweep: 64/128/256/512 with S_COUNT=3, random valid/ready, 1000 frames -> scoreboard matches per-source frame contents and counts.
- Single source: S_COUNT=1, 1-beat frames back-to-back -> grant_index stays 0, throughput 1 frame per 2 cycles.
